uart_rx_core: RTL and testbench

Serial receive engine of the UART. It oversamples the `rx` line at 16× the baud rate, using a tick derived from the runtime divisor `dvsr`, and deserialises 8N1 frames (optionally 8E1). Each completed byte is presented with a one-cycle `rx_done_tick` strobe. It sits directly upstream of the receive FIFO: `rx_done_tick` is the FIFO write enable, and `rx_data` is the FIFO write data that later appears on `r_data` under `rd_uart`.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_baud_gen.sv | 21 ++
 rtl/uart_rx_core.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state type and oversampling/divisor constants.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;
  localparam int OVERSAMPLE = 16;
  localparam int DVSR_W     = 11;
endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one tick every dvsr+1 clocks. Shared by the UART receiver and transmitter.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              tick
);
  logic [DVSR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == dvsr);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: 16x oversampled 8N1 deserialiser with frame error flag.
// Optional even-parity bit and parity_err flag when UART_RX_PARITY_EN is defined.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              rx,
  output logic [DBIT-1:0]   rx_data,
  output logic              rx_done_tick,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  logic            tick;
  logic            sync_q, rx_s_q;
  uart_rx_state_t  state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            perr_q, perr_d;
`endif

  uart_baud_gen u_baud_gen (
    .clock (clock),
    .reset (reset),
    .dvsr  (dvsr),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          // Re-check the line at mid start bit to reject glitches
          if (s_q == 4'(OVERSAMPLE / 2 - 1)) begin
            s_d = '0;
            if (!rx_s_q) begin
              state_d = DATA;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == 4'(OVERSAMPLE - 1)) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_q == 4'(OVERSAMPLE - 1)) begin
            par_d   = rx_s_q;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_q == 4'(SB_TICK - 1)) begin
            done_d  = 1'b1;
            data_d  = b_q;
            ferr_d  = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^b_q) ^ par_q;
`endif
            s_d     = '0;
            state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= rx;
      rx_s_q  <= sync_q;
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign rx_data      = data_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign busy         = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized bench for uart_rx_core: frames are generated bit by bit and received strobes compared with expected frames.
module tb_uart_rx_core;
  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] dvsr  = '0;
  logic        rx    = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_done_tick, frame_err, parity_err, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         cyc;
    int         tol;
  } frame_t;

  frame_t exp_q[$];
  frame_t got_q[$];

  uart_rx_core #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clock        (clock),
    .reset        (reset),
    .dvsr         (dvsr),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .busy         (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock)
    if (!reset && rx_done_tick)
      got_q.push_back('{d: rx_data, fe: frame_err, pe: parity_err, cyc: cyc, tol: 0});

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic int tick_len();
    return int'(dvsr) + 1;
  endfunction

  task automatic set_dvsr(input int v);
    @(negedge clock);
    reset = 1'b1;
    dvsr  = 11'(v);
    wait_clks(2);
    reset = 1'b0;
    wait_clks(3);
  endtask

  task automatic drive_bit(input logic v, input int ticks);
    rx = v;
    wait_clks(ticks * tick_len());
  endtask

  // A bad stop bit is held low only for its first 10 ticks so the re-armed start detector rejects it.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit pbit, input int gap_ticks);
    frame_t e;
    @(negedge clock);
    e.d   = d;
    e.fe  = !stop_ok;
    e.pe  = (P != 0) ? ((^d) ^ pbit) : 1'b0;
    e.cyc = cyc + 3 + (8 + 16 * DBIT + 16 * P + SB_TICK) * tick_len();
    e.tol = tick_len();
    exp_q.push_back(e);
    drive_bit(1'b0, 16);
    for (int i = 0; i < DBIT; i++) drive_bit(d[i], 16);
    if (P != 0) drive_bit(pbit, 16);
    if (stop_ok) drive_bit(1'b1, 16);
    else begin
      drive_bit(1'b0, 10);
      drive_bit(1'b1, 22);
    end
    drive_bit(1'b1, gap_ticks);
  endtask

  task automatic check_frames(input string tag);
    int n;
    int diff;
    wait_clks(4);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_%0d_data", tag, i), 32'(got_q[i].d), 32'(exp_q[i].d));
      check_eq($sformatf("%s_%0d_ferr", tag, i), 32'(got_q[i].fe), 32'(exp_q[i].fe));
      check_eq($sformatf("%s_%0d_perr", tag, i), 32'(got_q[i].pe), 32'(exp_q[i].pe));
      diff = exp_q[i].cyc - got_q[i].cyc;
      check_eq($sformatf("%s_%0d_latency_cyc%0d_nominal%0d", tag, i, got_q[i].cyc, exp_q[i].cyc),
               32'((diff >= -1 && diff <= exp_q[i].tol) ? 1 : 0), 32'd1);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int spacing;
    int tl;
    bit ok;
    bit pb;
    logic [7:0] d;

    rx = 1'b1;
    reset = 1'b1;
    wait_clks(5);
    check_eq("rst_data", 32'(rx_data), 32'h0);
    check_eq("rst_done", 32'(rx_done_tick), 32'h0);
    check_eq("rst_ferr", 32'(frame_err), 32'h0);
    check_eq("rst_perr", 32'(parity_err), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    wait_clks(5);

    // Clean frame at the fastest divisor
    set_dvsr(0);
    send_frame(8'hA5, 1'b1, ^8'hA5, 16);
    check_eq("a5_busy_after", 32'(busy), 32'h0);
    check_frames("a5");

    // Short low pulse: glitch rejection at mid start bit
    set_dvsr(1);
    tl = tick_len();
    rx = 1'b0;
    wait_clks(4 * tl);
    check_eq("glitch_busy_during", 32'(busy), 32'h1);
    rx = 1'b1;
    wait_clks(8 * tl);
    check_eq("glitch_busy_after", 32'(busy), 32'h0);
    wait_clks(32 * tl);
    check_frames("glitch");

    // Framing error then clean frame
    set_dvsr(2);
    send_frame(8'h3C, 1'b0, ^8'h3C, 16);
    send_frame(8'h3C, 1'b1, ^8'h3C, 16);
    check_frames("ferr");

    // Back-to-back frames with no idle gap
    set_dvsr(0);
    tl = tick_len();
    send_frame(8'h00, 1'b1, ^8'h00, 0);
    send_frame(8'hFF, 1'b1, ^8'hFF, 16);
    wait_clks(4);
    check_eq("b2b_strobes", got_q.size(), 2);
    if (got_q.size() == 2) begin
      spacing = got_q[1].cyc - got_q[0].cyc;
      check_eq($sformatf("b2b_spacing_%0d", spacing),
               32'((spacing >= 16 * (DBIT + 2 + P) * tl - tl && spacing <= 16 * (DBIT + 2 + P) * tl + tl) ? 1 : 0),
               32'd1);
    end
    check_frames("b2b");

    // Reset during data bit 3 of 0x81
    set_dvsr(1);
    d = 8'h81;
    @(negedge clock);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) drive_bit(d[i], 16);
    drive_bit(d[3], 8);
    check_eq("midrst_busy_before", 32'(busy), 32'h1);
    reset = 1'b1;
    wait_clks(1);
    check_eq("midrst_data", 32'(rx_data), 32'h0);
    check_eq("midrst_done", 32'(rx_done_tick), 32'h0);
    check_eq("midrst_ferr", 32'(frame_err), 32'h0);
    check_eq("midrst_perr", 32'(parity_err), 32'h0);
    check_eq("midrst_busy", 32'(busy), 32'h0);
    rx = 1'b1;
    reset = 1'b0;
    wait_clks(12 * 16 * tick_len());
    check_frames("midrst");
    send_frame(8'h5A, 1'b1, ^8'h5A, 16);
    check_frames("after_rst");

    // Randomized frames: data, stop-bit validity, parity bit, idle gaps
    for (int blk = 0; blk < 3; blk++) begin
      set_dvsr(int'($urandom_range(0, 3)));
      for (int k = 0; k < 6; k++) begin
        d  = 8'($urandom_range(0, 255));
        ok = ($urandom_range(0, 3) != 0);
        pb = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
        wait_clks(int'($urandom_range(0, 5)));
        send_frame(d, ok, pb, ok ? int'($urandom_range(0, 1) * $urandom_range(1, 16)) : 16);
      end
      check_frames($sformatf("rand%0d", blk));
    end

`ifdef UART_RX_PARITY_EN
    set_dvsr(162);
    send_frame(8'h07, 1'b1, 1'b1, 16);
    send_frame(8'h07, 1'b1, 1'b0, 16);
    wait_clks(4);
    if (got_q.size() == 2) begin
      check_eq("par_good_perr", 32'(got_q[0].pe), 32'h0);
      check_eq("par_bad_perr", 32'(got_q[1].pe), 32'h1);
    end
    check_frames("parity");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
